shift_add_multiplier: RTL

//  Sequential unsigned shift-add multiplier for the ALU datapath; inverse of the restoring divider.

---
 rtl/shift_add_multiplier_if.sv | 12 +
 rtl/shift_add_multiplier.sv | 87 ++++++++
 2 files changed

// File: rtl/shift_add_multiplier_if.sv
// Opcode/operand bus shared by the ALU control unit and the shift-add multiplier.
interface shift_add_multiplier_if #(parameter int WIDTH = 32);
  logic [5:0]         signal;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] dataout;
  logic               busy;
  logic               done;

  modport master (output signal, multiplicand, multiplier, input dataout, busy, done);
  modport slave  (input signal, multiplicand, multiplier, output dataout, busy, done);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one product bit per clock, {HI,LO} returned on OUT.
// Optional signed multiply (MULT opcode) is built when SIGNED_MULT_EN is defined.
module shift_add_multiplier #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] OUT   = 6'b111111
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, result, dataout_r;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_nxt, prod_fin;
    logic               start;
    logic [WIDTH-1:0]   a_op, b_op;

    // Carry out of the partial-sum add becomes the new product MSB after the shift.
    assign sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nxt = {sum, prod[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
    localparam logic [5:0] MULT = 6'b011000;
    logic signed_op, sign_in, sign;

    assign signed_op = (bus.signal == MULT);
    assign start     = (state == IDLE) && ((bus.signal == MULTU) || signed_op);
    // Signed operands are reduced to magnitudes; the sign is reapplied to the final product.
    assign a_op      = (signed_op && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
    assign b_op      = (signed_op && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
    assign sign_in   = signed_op && (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
    assign prod_fin  = sign ? -prod_nxt : prod_nxt;

    always_ff @(posedge clk) begin
        if (reset)      sign <= 1'b0;
        else if (start) sign <= sign_in;
    end
`else
    assign start    = (state == IDLE) && (bus.signal == MULTU);
    assign a_op     = bus.multiplicand;
    assign b_op     = bus.multiplier;
    assign prod_fin = prod_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            prod      <= '0;
            result    <= '0;
            dataout_r <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand <= a_op;
                    prod  <= {{WIDTH{1'b0}}, b_op};
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    prod  <= prod_nxt;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        result <= prod_fin;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // In DONE, result already holds the freshly finished product.
            if (bus.signal == OUT && state != RUN)
                dataout_r <= result;
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.dataout = dataout_r;
endmodule
